// File: rtl/rom_fetch_sequencer.sv
// Program-counter-driven fetch unit: walks the instruction ROM and hands each word
// to decode through a one-entry valid/ready output register, with branch redirect.
module rom_fetch_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int PROG_LEN   = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_enable,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PC  = ADDR_WIDTH'(PROG_LEN - 1);
  localparam logic [ADDR_WIDTH:0]   PROG_END = (ADDR_WIDTH + 1)'(PROG_LEN);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  cap;
  logic                  redirect_in_range;

  // Handshake: an entry transfers on a clock edge where instr_valid & instr_ready.
  // The output slot can take a new word when it is empty or being drained this cycle.
  assign cap               = !instr_valid || instr_ready;
  assign redirect_in_range = {1'b0, redirect_addr} < PROG_END;

  assign rom_address = pc;
  assign rom_enable  = (state == FETCH);
  assign busy        = (state == FETCH) || (state == DRAIN);
  assign done        = (state == DONE);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          // Redirect wins over capture; the pending entry is dropped, not consumed.
          if (redirect) begin
            instr_valid <= 1'b0;
            if (redirect_in_range) pc <= redirect_addr;
            else                   state <= DONE;
          end else if (cap) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 1'b1;
            if (pc == LAST_PC) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            if (redirect_in_range) begin
              pc    <= redirect_addr;
              state <= FETCH;
            end else begin
              state <= DONE;
            end
          end else if (cap) begin
            instr_valid <= 1'b0;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: transaction-level reference model checked every cycle,
// a consumed-address scoreboard for directed runs, and a randomized soak.
module tb_rom_fetch_sequencer;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PL = 19;

  logic          clk = 1'b0;
  logic          reset, start, instr_ready, redirect;
  logic [AW-1:0] redirect_addr, rom_address, instr_pc;
  logic          rom_enable, instr_valid, busy, done;
  logic [DW-1:0] rom_data, instr;
  logic [1:0]    state_dbg;
  logic [DW-1:0] rom_mem [0:31];

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_q[$];
  bit            sb_on = 1'b0;

  // Reference model: whether a program is running, the next address to fetch,
  // the entry in the output slot, and whether the last run finished.
  bit m_live = 1'b0;
  bit m_act, m_fin, m_ev;
  int m_next, m_epc;

  always #5 clk = ~clk;

  assign rom_data = rom_enable ? rom_mem[rom_address] : '0;

  rom_fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_LEN(PL)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_address(rom_address), .rom_enable(rom_enable), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; m_fin = 0; m_ev = 0; m_next = 0; m_epc = 0; m_live = 1;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_fin = 0; m_next = 0;
      end
    end else if (redirect) begin
      m_ev = 0;
      if (int'(redirect_addr) < PL) m_next = int'(redirect_addr);
      else begin m_act = 0; m_fin = 1; end
    end else if (!m_ev || instr_ready) begin
      if (m_next < PL) begin
        m_ev = 1; m_epc = m_next; m_next++;
      end else begin
        m_ev = 0; m_act = 0; m_fin = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("busy", busy, m_act);
      check("done", done, m_fin);
      check("rom_enable", rom_enable, m_act && m_next < PL);
      check("rom_address", rom_address, m_next[AW-1:0]);
      check("instr_valid", instr_valid, m_ev);
      if (m_ev && instr_valid) begin
        check("instr_pc", instr_pc, m_epc[AW-1:0]);
        check("instr", instr, rom_mem[m_epc]);
      end
    end
    if (sb_on && !reset && !redirect && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra: consumed pc %0d, expected no further handshake", instr_pc);
      end else begin
        check("sb_pc", instr_pc, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_range(input int a, input int b);
    for (int i = a; i <= b; i++) exp_q.push_back(i[AW-1:0]);
  endtask

  task automatic wait_pc(input int p);
    for (int k = 0; k < 100; k++) begin
      if (instr_valid && int'(instr_pc) == p) return;
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_pc: got instr_pc %0d valid %0b expected pc %0d within 100 cycles", instr_pc, instr_valid, p);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        check("sb_empty", exp_q.size(), 0);
        return;
      end
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_done: got done %0b expected 1 within 200 cycles", done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", instr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enable", rom_enable, 0);
    check("rst_address", rom_address, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Full program with ready held high: one word per cycle.
    sb_on = 1'b1;
    push_range(0, 18);
    pulse_start();
    check("s1_enable", rom_enable, 1);
    check("s1_first_valid", instr_valid, 0);
    tick();
    check("s1_valid", instr_valid, 1);
    check("s1_pc0", instr_pc, 0);
    check("s1_instr0", instr, rom_mem[0]);
    repeat (18) tick();
    check("s1_pc18", instr_pc, 18);
    check("s1_enable_off", rom_enable, 0);
    check("s1_busy_drain", busy, 1);
    tick();
    check("s1_done", done, 1);
    check("s1_busy", busy, 0);
    check("s1_sb_empty", exp_q.size(), 0);

    // Backpressure at pc 3.
    push_range(0, 18);
    pulse_start();
    wait_pc(3);
    instr_ready = 1'b0;
    repeat (5) begin
      tick();
      check("s2_hold_pc", instr_pc, 3);
      check("s2_hold_addr", rom_address, 4);
      check("s2_hold_instr", instr, rom_mem[3]);
      check("s2_hold_valid", instr_valid, 1);
    end
    instr_ready = 1'b1;
    wait_done();

    // In-range redirect while pc 5 is presented.
    push_range(0, 4);
    push_range(10, 18);
    pulse_start();
    wait_pc(5);
    redirect = 1'b1; redirect_addr = 5'd10;
    tick();
    redirect = 1'b0;
    check("s3_bubble", instr_valid, 0);
    tick();
    check("s3_valid", instr_valid, 1);
    check("s3_pc10", instr_pc, 10);
    wait_done();

    // Out-of-range redirect ends the run.
    push_range(0, 5);
    pulse_start();
    wait_pc(6);
    redirect = 1'b1; redirect_addr = 5'd25;
    tick();
    redirect = 1'b0;
    check("s4_valid", instr_valid, 0);
    check("s4_done", done, 1);
    check("s4_busy", busy, 0);
    check("s4_sb_empty", exp_q.size(), 0);

    // Reset mid-run, then restart from 0.
    push_range(0, 6);
    pulse_start();
    wait_pc(7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_valid", instr_valid, 0);
    check("s5_instr", instr, 0);
    check("s5_instr_pc", instr_pc, 0);
    check("s5_address", rom_address, 0);
    check("s5_busy", busy, 0);
    check("s5_done", done, 0);
    check("s5_sb_empty", exp_q.size(), 0);
    push_range(0, 18);
    pulse_start();
    wait_done();

    // Start while busy is ignored; start in DONE restarts.
    push_range(0, 18);
    pulse_start();
    wait_pc(2);
    pulse_start();
    wait_done();
    push_range(0, 18);
    pulse_start();
    check("s6_restart_addr", rom_address, 0);
    check("s6_restart_busy", busy, 1);
    wait_done();

    // Randomized soak against the model.
    sb_on = 1'b0;
    repeat (2000) begin
      instr_ready   = ($urandom_range(0, 3) != 0);
      start         = ($urandom_range(0, 15) == 0);
      redirect      = ($urandom_range(0, 19) == 0);
      redirect_addr = 5'($urandom_range(0, 31));
      reset         = ($urandom_range(0, 299) == 0);
      tick();
    end
    start = 1'b0; redirect = 1'b0; reset = 1'b0; instr_ready = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_fetch_sequencer.md
Name: rom_fetch_sequencer

Overview:
- Sequences the 32-entry instruction ROM (5-bit address, enable, 32-bit combinational read, PROG_LEN valid words) as a program-counter-driven fetch unit.
- Presents fetched instructions to downstream decode over a valid/ready handshake, with a one-entry output register.
- Supports a branch redirect that flushes the output register.
- Sits between the ROM and the decode/execute stage.

Parameters:
ADDR_WIDTH, 5, ROM address width
DATA_WIDTH, 32, instruction width
PROG_LEN, 19, number of valid program words; fetch stops after address PROG_LEN-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins fetch from address 0 when IDLE or DONE
rom_address  output  ADDR_WIDTH  address to ROM, equals pc
rom_enable  output  1  ROM enable, high only in FETCH
rom_data  input  DATA_WIDTH  ROM read data, combinational from rom_address/rom_enable
instr  output  DATA_WIDTH  registered instruction
instr_pc  output  ADDR_WIDTH  address instr was fetched from
instr_valid  output  1  instr/instr_pc hold a valid entry
instr_ready  input  1  consumer accepts entry when instr_valid & instr_ready
redirect  input  1  branch taken; flush and refetch
redirect_addr  input  ADDR_WIDTH  new pc on redirect
busy  output  1  high in FETCH or DRAIN
done  output  1  high in DONE (level)

Behaviour:
- Reset, sampled on the clk edge: state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, rom_enable=0, rom_address=0, busy=0, done=0. Reset mid-operation aborts immediately with no further handshakes.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE/DONE, start=1: pc<=0, go to FETCH, done drops next cycle. redirect is ignored in these states.
- FETCH:
  - rom_enable=1, rom_address=pc.
  - Capture condition: cap = !instr_valid | instr_ready.
  - If cap: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
  - If cap and pc==PROG_LEN-1: go to DRAIN.
  - If !cap: hold pc and the output register. The ROM stays enabled at the same address.
  - Throughput with instr_ready held high: 1 instruction per cycle.
  - Latency: instr_valid rises the cycle after entering FETCH.
- DRAIN:
  - rom_enable=0.
  - When instr_valid & instr_ready, or when instr_valid=0: instr_valid<=0 and go to DONE.
- Handshake rules:
  - A consume with no capture clears instr_valid.
  - While instr_valid=1 and instr_ready=0, instr and instr_pc are stable.
- Redirect (FETCH or DRAIN) has priority over capture and consume:
  - instr_valid<=0 (entry discarded, not counted as consumed).
  - If redirect_addr < PROG_LEN: pc<=redirect_addr and go to FETCH. First redirected instruction is valid 2 cycles after the redirect cycle.
  - Else: go to DONE.
- start while busy is ignored. start together with redirect in IDLE behaves as start.
- pc arithmetic is ADDR_WIDTH-bit unsigned. pc never exceeds PROG_LEN-1 while in FETCH, so no wrap occurs.
- busy = (state==FETCH) | (state==DRAIN). done = (state==DONE).

Test Plan:
1. Reset, then start pulse, instr_ready=1 constant -> instr_pc 0..18 on 19 consecutive cycles; instr matches ROM word at each address; done=1 one cycle after the last handshake; rom_enable low after address 18.
2. Start, instr_ready low for 5 cycles while instr_pc=3 -> instr, instr_pc=3 and rom_address=4 stay stable; pc does not advance; no instruction skipped or duplicated after ready returns.
3. Redirect with redirect_addr=10 on the cycle instr_pc=5 is valid -> entry 5 is not consumed; instr_valid=0 for one cycle; next valid instr_pc=10, then 11..18, then done.
4. Redirect with redirect_addr=25 mid-run -> instr_valid=0, state DONE next cycle, done=1, busy=0.
5. Assert reset while instr_pc=7 is valid -> next cycle all outputs 0, state IDLE; a subsequent start fetches from address 0.
6. Start pulse during FETCH at instr_pc=2 -> ignored, sequence continues 3,4,...; start in DONE restarts from 0.
